// File: rtl/inst_fetch.sv
// Thumb instruction fetch: issues one 32-bit read at a time and queues the
// returned halfwords with their PCs in a 4-entry FIFO for decode.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int DEPTH = 4;

    logic [31:0] fetch_pc_reg;
    logic        req_reg;
    logic [31:0] addr_reg;
    logic        drop_reg;
    logic [2:0]  count_reg;
    logic [1:0]  head_reg;
    logic [1:0]  tail_reg;

    logic [15:0] half_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];

    logic [31:0] fetch_word;
    logic [1:0]  tail_inc;
    logic        ack_take;
    logic        keep;
    logic        push_lo;
    logic        push_hi;
    logic        pop;
    logic        issue;
    logic [1:0]  n_push;
    logic        unused_bits;

    assign fetch_word = {fetch_pc_reg[31:2], 2'b00};
    assign tail_inc   = tail_reg + 2'd1;

    // Data is queued only for a live request that is neither being dropped
    // nor overtaken by a redirect in the same cycle.
    assign ack_take = req_reg & imem_ack;
    assign keep     = ack_take & ~drop_reg & ~branch_valid;
    assign push_lo  = keep & ~fetch_pc_reg[1];
    assign push_hi  = keep;
    assign n_push   = {1'b0, push_lo} + {1'b0, push_hi};
    assign pop      = inst_valid & inst_ready & ~branch_valid;

    // Issuing only when two slots are free guarantees room for a full word.
    assign issue = ~req_reg & (count_reg <= 3'd2) & ~branch_valid;

    assign unused_bits = ^{branch_target[0], fetch_pc_reg[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg <= {RESET_PC[31:1], 1'b0};
            req_reg      <= 1'b0;
            addr_reg     <= {RESET_PC[31:2], 2'b00};
            drop_reg     <= 1'b0;
            count_reg    <= 3'd0;
            head_reg     <= 2'd0;
            tail_reg     <= 2'd0;
        end else if (branch_valid) begin
            count_reg    <= 3'd0;
            head_reg     <= 2'd0;
            tail_reg     <= 2'd0;
            fetch_pc_reg <= {branch_target[31:1], 1'b0};
            if (req_reg && imem_ack) begin
                req_reg  <= 1'b0;
                drop_reg <= 1'b0;
            end else if (req_reg) begin
                drop_reg <= 1'b1;
            end
        end else begin
            if (ack_take) begin
                req_reg  <= 1'b0;
                drop_reg <= 1'b0;
                if (!drop_reg) begin
                    fetch_pc_reg <= fetch_word + 32'd4;
                end
            end else if (issue) begin
                req_reg  <= 1'b1;
                addr_reg <= fetch_word;
            end
            count_reg <= count_reg + {1'b0, n_push} - {2'b00, pop};
            head_reg  <= head_reg + {1'b0, pop};
            tail_reg  <= tail_reg + n_push;
        end
    end

    // Queue storage needs no reset: count gates everything visible.
    always_ff @(posedge clk) begin
        if (push_lo) begin
            half_mem[tail_reg] <= imem_rdata[15:0];
            pc_mem[tail_reg]   <= fetch_word;
            half_mem[tail_inc] <= imem_rdata[31:16];
            pc_mem[tail_inc]   <= fetch_word + 32'd2;
        end else if (push_hi) begin
            half_mem[tail_reg] <= imem_rdata[31:16];
            pc_mem[tail_reg]   <= fetch_word + 32'd2;
        end
    end

    assign imem_req   = req_reg;
    assign imem_addr  = addr_reg;
    assign inst_valid = (count_reg != 3'd0);
    assign inst       = half_mem[head_reg];
    assign inst_pc    = pc_mem[head_reg];

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: one instance at RESET_PC=0, one at the
// top of the address space to exercise fetch_pc wrap.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        branch_valid;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [15:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    logic        imem_req_1;
    logic [31:0] imem_addr_1;
    logic        imem_ack_1;
    logic [31:0] imem_rdata_1;
    logic        inst_valid_1;
    logic [15:0] inst_1;
    logic [31:0] inst_pc_1;
    logic        inst_ready_1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk           (clk),
        .rst_n         (rst_n),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .branch_valid  (1'b0),
        .branch_target (32'h0),
        .imem_req      (imem_req_1),
        .imem_addr     (imem_addr_1),
        .imem_ack      (imem_ack_1),
        .imem_rdata    (imem_rdata_1),
        .inst_valid    (inst_valid_1),
        .inst          (inst_1),
        .inst_pc       (inst_pc_1),
        .inst_ready    (inst_ready_1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        branch_valid  = 1'b0;
        branch_target = 32'h0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        inst_ready    = 1'b0;
        imem_ack_1    = 1'b0;
        imem_rdata_1  = 32'h0;
        inst_ready_1  = 1'b0;

        #2;
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_req_1", {31'b0, imem_req_1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait ack, decode always ready
        step();
        check("a_req", {31'b0, imem_req}, 32'd1);
        check("a_addr", imem_addr, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h2222_1111; inst_ready = 1'b1;
        step();
        check("a_inst0", {16'b0, inst}, 32'h1111);
        check("a_pc0", inst_pc, 32'h0);
        check("a_req_drop", {31'b0, imem_req}, 32'd0);
        imem_ack = 1'b0;
        step();
        check("a_inst1", {16'b0, inst}, 32'h2222);
        check("a_pc1", inst_pc, 32'h2);
        check("a_req2", {31'b0, imem_req}, 32'd1);
        check("a_addr2", imem_addr, 32'h4);

        // Asynchronous reset between edges with a request outstanding
        #2;
        rst_n = 1'b0;
        #1;
        check("b_req", {31'b0, imem_req}, 32'd0);
        check("b_valid", {31'b0, inst_valid}, 32'd0);
        inst_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Fill the queue with decode stalled
        step();
        check("c_valid0", {31'b0, inst_valid}, 32'd0);
        check("c_addr0", imem_addr, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h2222_1111;
        step();
        check("c_inst0", {16'b0, inst}, 32'h1111);
        check("c_req_lo0", {31'b0, imem_req}, 32'd0);
        imem_ack = 1'b0;
        step();
        check("c_addr1", imem_addr, 32'h4);
        imem_ack = 1'b1; imem_rdata = 32'h4444_3333;
        step();
        check("c_req_full", {31'b0, imem_req}, 32'd0);
        imem_ack = 1'b0;
        step();
        check("c_req_stall", {31'b0, imem_req}, 32'd0);
        check("c_head_hold", {16'b0, inst}, 32'h1111);
        inst_ready = 1'b1;
        step();
        check("c_pop1", {16'b0, inst}, 32'h2222);
        check("c_req_pop1", {31'b0, imem_req}, 32'd0);
        step();
        check("c_pop2", {16'b0, inst}, 32'h3333);
        check("c_pop2_pc", inst_pc, 32'h4);
        check("c_req_pop2", {31'b0, imem_req}, 32'd0);
        inst_ready = 1'b0;
        step();
        check("c_resume", {31'b0, imem_req}, 32'd1);
        check("c_resume_addr", imem_addr, 32'h8);

        // Branch coinciding with ack (data discarded), odd-halfword target
        branch_valid = 1'b1; branch_target = 32'h0000_0107;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        check("d_flush", {31'b0, inst_valid}, 32'd0);
        check("d_req_off", {31'b0, imem_req}, 32'd0);
        branch_valid = 1'b0; imem_ack = 1'b0;
        step();
        check("d_addr", imem_addr, 32'h104);
        check("d_req", {31'b0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'hBBBB_AAAA;
        step();
        check("d_inst", {16'b0, inst}, 32'hBBBB);
        check("d_pc", inst_pc, 32'h106);
        imem_ack = 1'b0;
        step();
        check("d_next_addr", imem_addr, 32'h108);
        check("d_one_entry", {16'b0, inst}, 32'hBBBB);

        // Branch while a request waits; its late data must be dropped
        branch_valid = 1'b1; branch_target = 32'h0000_0200;
        step();
        check("e_flush", {31'b0, inst_valid}, 32'd0);
        check("e_hold_req", {31'b0, imem_req}, 32'd1);
        check("e_hold_addr", imem_addr, 32'h108);
        branch_valid = 1'b0;
        step();
        check("e_hold2", imem_addr, 32'h108);
        step();
        check("e_hold3", {31'b0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h9999_8888;
        step();
        check("e_dropped", {31'b0, inst_valid}, 32'd0);
        check("e_req_off", {31'b0, imem_req}, 32'd0);
        imem_ack = 1'b0;
        step();
        check("e_target_req", {31'b0, imem_req}, 32'd1);
        check("e_target_addr", imem_addr, 32'h200);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        check("e_inst", {16'b0, inst}, 32'h5678);
        check("e_pc", inst_pc, 32'h200);
        imem_ack = 1'b0;

        // Address wrap on the high-reset instance
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("f_req", {31'b0, imem_req_1}, 32'd1);
        check("f_addr", imem_addr_1, 32'hFFFF_FFFC);
        imem_ack_1 = 1'b1; imem_rdata_1 = 32'hBEEF_CAFE; inst_ready_1 = 1'b1;
        step();
        check("f_inst0", {16'b0, inst_1}, 32'hCAFE);
        check("f_pc0", inst_pc_1, 32'hFFFF_FFFC);
        imem_ack_1 = 1'b0;
        step();
        check("f_inst1", {16'b0, inst_1}, 32'hBEEF);
        check("f_pc1", inst_pc_1, 32'hFFFF_FFFE);
        check("f_wrap_addr", imem_addr_1, 32'h0);
        check("f_wrap_req", {31'b0, imem_req_1}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
